// File: rtl/warp_reg_file.sv
// Per-warp, per-lane register file with a dual-operand read port, a masked write port
// and a background warp-clear engine. Special read-only registers expose thread/block ids.
`ifndef DATA_WIDTH
`define DATA_WIDTH 32
`endif

module warp_reg_file #(
   parameter int THREADS_PER_WARP = 16,
   parameter int NUM_WARPS        = 4,
   parameter int DATA_WIDTH       = `DATA_WIDTH,
   parameter int NUM_REGS         = 32,
   parameter int HAS_SPECIAL_REGS = 1,
   localparam int RW = $clog2(NUM_REGS),
   localparam int WW = (NUM_WARPS > 1) ? $clog2(NUM_WARPS) : 1
) (
   input  logic                        clk,
   input  logic                        reset_n,
   input  logic [DATA_WIDTH-1:0]       block_id,
   input  logic [DATA_WIDTH-1:0]       block_size,
   input  logic                        rd_req_valid,
   output logic                        rd_req_ready,
   input  logic [WW-1:0]               rd_warp,
   input  logic [RW-1:0]               rd_rs1_addr,
   input  logic [RW-1:0]               rd_rs2_addr,
   output logic                        rd_resp_valid,
   output logic [DATA_WIDTH-1:0]       rs1 [THREADS_PER_WARP],
   output logic [DATA_WIDTH-1:0]       rs2 [THREADS_PER_WARP],
   input  logic                        wr_valid,
   input  logic [WW-1:0]               wr_warp,
   input  logic [RW-1:0]               wr_rd_addr,
   input  logic [THREADS_PER_WARP-1:0] wr_thread_mask,
   input  logic [DATA_WIDTH-1:0]       wr_data [THREADS_PER_WARP],
   input  logic                        clr_start,
   input  logic [WW-1:0]               clr_warp,
   output logic                        clr_busy
);

   localparam logic [RW-1:0] ADDR_TID   = RW'(NUM_REGS - 3);
   localparam logic [RW-1:0] ADDR_BID   = RW'(NUM_REGS - 2);
   localparam logic [RW-1:0] ADDR_BSIZE = RW'(NUM_REGS - 1);

   typedef enum logic {IDLE, CLEAR} state_t;

   state_t                state_q, state_d;
   logic [RW-1:0]         clr_cnt_q, clr_cnt_d;
   logic [WW-1:0]         clr_warp_q, clr_warp_d;
   logic                  rd_accept;
   logic                  wr_commit;
   logic [RW-1:0]         src_addr [2];
   logic [DATA_WIDTH-1:0] rd_data [2][THREADS_PER_WARP];
   logic [DATA_WIDTH-1:0] regs_q [NUM_WARPS][THREADS_PER_WARP][NUM_REGS];

   // Address 0 and the special registers have no writable storage.
   function automatic logic is_protected(input logic [RW-1:0] addr);
      return (addr == '0) || ((HAS_SPECIAL_REGS != 0) && (addr >= ADDR_TID));
   endfunction

   assign clr_busy     = (state_q == CLEAR);
   assign rd_req_ready = !clr_busy;
   assign rd_accept    = rd_req_valid && rd_req_ready;
   assign wr_commit    = wr_valid && !is_protected(wr_rd_addr)
                         && !(clr_busy && (wr_warp == clr_warp_q));
   assign src_addr[0]  = rd_rs1_addr;
   assign src_addr[1]  = rd_rs2_addr;

   // NOTE: every always_comb output is given a default first so no path leaves it
   // unassigned; otherwise synthesis infers a latch to hold the old value.
   always_comb begin
      state_d    = state_q;
      clr_cnt_d  = clr_cnt_q;
      clr_warp_d = clr_warp_q;
      case (state_q)
         IDLE: begin
            if (clr_start) begin
               state_d    = CLEAR;
               clr_cnt_d  = RW'(1);
               clr_warp_d = clr_warp;
            end
         end
         CLEAR: begin
            if (clr_cnt_q == ADDR_BSIZE) begin
               state_d   = IDLE;
               clr_cnt_d = '0;
            end else begin
               clr_cnt_d = clr_cnt_q + RW'(1);
            end
         end
         default: state_d = IDLE;
      endcase
   end

   // NOTE: sequential state uses non-blocking assignments so every register samples
   // the pre-edge values, independent of statement order.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q    <= IDLE;
         clr_cnt_q  <= '0;
         clr_warp_q <= '0;
      end else begin
         state_q    <= state_d;
         clr_cnt_q  <= clr_cnt_d;
         clr_warp_q <= clr_warp_d;
      end
   end

   // Write-first: a same-edge write to the read target overrides stored data per lane.
   always_comb begin
      for (int s = 0; s < 2; s++) begin
         for (int lane = 0; lane < THREADS_PER_WARP; lane++) begin
            rd_data[s][lane] = regs_q[rd_warp][lane][src_addr[s]];
            if (wr_commit && (wr_warp == rd_warp) && (wr_rd_addr == src_addr[s])
                && wr_thread_mask[lane])
               rd_data[s][lane] = wr_data[lane];
            if (src_addr[s] == '0)
               rd_data[s][lane] = '0;
            else if (HAS_SPECIAL_REGS != 0) begin
               if (src_addr[s] == ADDR_TID)
                  rd_data[s][lane] = DATA_WIDTH'(int'(rd_warp) * THREADS_PER_WARP + lane);
               else if (src_addr[s] == ADDR_BID)
                  rd_data[s][lane] = block_id;
               else if (src_addr[s] == ADDR_BSIZE)
                  rd_data[s][lane] = block_size;
            end
         end
      end
   end

   // NOTE: the register array is reset explicitly because an asynchronous clear of
   // all warps is part of the contract; a RAM macro could not provide this.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         for (int w = 0; w < NUM_WARPS; w++)
            for (int lane = 0; lane < THREADS_PER_WARP; lane++)
               for (int r = 0; r < NUM_REGS; r++)
                  regs_q[w][lane][r] <= '0;
      end else begin
         if (clr_busy && !is_protected(clr_cnt_q))
            for (int lane = 0; lane < THREADS_PER_WARP; lane++)
               regs_q[clr_warp_q][lane][clr_cnt_q] <= '0;
         if (wr_commit)
            for (int lane = 0; lane < THREADS_PER_WARP; lane++)
               if (wr_thread_mask[lane])
                  regs_q[wr_warp][lane][wr_rd_addr] <= wr_data[lane];
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         rd_resp_valid <= 1'b0;
         for (int lane = 0; lane < THREADS_PER_WARP; lane++) begin
            rs1[lane] <= '0;
            rs2[lane] <= '0;
         end
      end else begin
         rd_resp_valid <= rd_accept;
         if (rd_accept)
            for (int lane = 0; lane < THREADS_PER_WARP; lane++) begin
               rs1[lane] <= rd_data[0][lane];
               rs2[lane] <= rd_data[1][lane];
            end
      end
   end

endmodule

// File: tb/tb_warp_reg_file.sv
// Self-checking bench for warp_reg_file: directed scenarios plus randomized traffic
// compared against an array-based reference model of the register file.
module tb_warp_reg_file;

   localparam int T  = 16;
   localparam int NW = 4;
   localparam int DW = 32;
   localparam int R  = 32;
   localparam int WW = 2;
   localparam int RW = 5;

   logic          clk = 1'b0;
   logic          reset_n;
   logic [DW-1:0] block_id, block_size;
   logic          rd_req_valid, rd_req_ready;
   logic [WW-1:0] rd_warp;
   logic [RW-1:0] rd_rs1_addr, rd_rs2_addr;
   logic          rd_resp_valid;
   logic [DW-1:0] rs1 [T];
   logic [DW-1:0] rs2 [T];
   logic          wr_valid;
   logic [WW-1:0] wr_warp;
   logic [RW-1:0] wr_rd_addr;
   logic [T-1:0]  wr_thread_mask;
   logic [DW-1:0] wr_data [T];
   logic          clr_start;
   logic [WW-1:0] clr_warp;
   logic          clr_busy;

   int n_tests = 0;
   int n_fail  = 0;

   // Reference model: stored registers, remaining clear cycles, expected response.
   logic [DW-1:0] model [NW][T][R];
   int            clr_left;
   int            clr_warp_m;
   logic          exp_valid;
   logic [DW-1:0] exp_rs1 [T];
   logic [DW-1:0] exp_rs2 [T];

   always #5 clk = ~clk;

   warp_reg_file #(.DATA_WIDTH(DW)) dut (
      .clk(clk), .reset_n(reset_n), .block_id(block_id), .block_size(block_size),
      .rd_req_valid(rd_req_valid), .rd_req_ready(rd_req_ready), .rd_warp(rd_warp),
      .rd_rs1_addr(rd_rs1_addr), .rd_rs2_addr(rd_rs2_addr), .rd_resp_valid(rd_resp_valid),
      .rs1(rs1), .rs2(rs2), .wr_valid(wr_valid), .wr_warp(wr_warp), .wr_rd_addr(wr_rd_addr),
      .wr_thread_mask(wr_thread_mask), .wr_data(wr_data), .clr_start(clr_start),
      .clr_warp(clr_warp), .clr_busy(clr_busy)
   );

   function automatic logic [DW-1:0] ref_read(int w, int a, int lane);
      if (a == 0)     return '0;
      if (a == R - 3) return DW'(w * T + lane);
      if (a == R - 2) return block_id;
      if (a == R - 1) return block_size;
      return model[w][lane][a];
   endfunction

   task automatic idle_inputs();
      rd_req_valid = 1'b0; rd_warp = '0; rd_rs1_addr = '0; rd_rs2_addr = '0;
      wr_valid = 1'b0; wr_warp = '0; wr_rd_addr = '0; wr_thread_mask = '0;
      clr_start = 1'b0; clr_warp = '0;
      for (int i = 0; i < T; i++) wr_data[i] = '0;
   endtask

   task automatic model_reset();
      for (int w = 0; w < NW; w++)
         for (int l = 0; l < T; l++)
            for (int r = 0; r < R; r++) model[w][l][r] = '0;
      clr_left  = 0;
      exp_valid = 1'b0;
      for (int l = 0; l < T; l++) begin exp_rs1[l] = '0; exp_rs2[l] = '0; end
   endtask

   // Advance one clock: update the model from the current inputs, then sample #1 later.
   task automatic tick();
      bit busy_before;
      busy_before = (clr_left > 0);
      if (wr_valid && wr_rd_addr != 0 && int'(wr_rd_addr) < R - 3
          && !(busy_before && int'(wr_warp) == clr_warp_m))
         for (int l = 0; l < T; l++)
            if (wr_thread_mask[l]) model[wr_warp][l][wr_rd_addr] = wr_data[l];
      exp_valid = rd_req_valid && !busy_before;
      if (exp_valid)
         for (int l = 0; l < T; l++) begin
            exp_rs1[l] = ref_read(int'(rd_warp), int'(rd_rs1_addr), l);
            exp_rs2[l] = ref_read(int'(rd_warp), int'(rd_rs2_addr), l);
         end
      if (busy_before) clr_left--;
      else if (clr_start) begin
         clr_left   = R - 1;
         clr_warp_m = int'(clr_warp);
         for (int l = 0; l < T; l++)
            for (int r = 0; r < R; r++) model[clr_warp_m][l][r] = '0;
      end
      @(posedge clk);
      #1;
   endtask

   task automatic write_all(int w, int a, logic [DW-1:0] base);
      wr_valid = 1'b1; wr_warp = WW'(w); wr_rd_addr = RW'(a); wr_thread_mask = '1;
      for (int i = 0; i < T; i++) wr_data[i] = base + DW'(i);
   endtask

   task automatic test_reset();
      int bad;
      idle_inputs();
      block_id = '0; block_size = '0;
      reset_n = 1'b0;
      #12;
      n_tests++;
      if (rd_resp_valid !== 1'b0 || clr_busy !== 1'b0 || rd_req_ready !== 1'b1) begin
         n_fail++;
         $display("FAIL reset_status: valid=%b busy=%b ready=%b required 0 0 1",
                  rd_resp_valid, clr_busy, rd_req_ready);
      end
      bad = -1;
      for (int i = 0; i < T; i++) if ((rs1[i] !== '0 || rs2[i] !== '0) && bad < 0) bad = i;
      n_tests++;
      if (bad >= 0) begin
         n_fail++;
         $display("FAIL reset_data lane %0d: rs1=%h rs2=%h required 0", bad, rs1[bad], rs2[bad]);
      end
      @(posedge clk); #1;
      reset_n = 1'b1;
      model_reset();
   endtask

   task automatic test_write_read();
      int bad;
      write_all(2, 5, 32'hA5A5_0000);
      tick();
      idle_inputs();
      rd_req_valid = 1'b1; rd_warp = 2'd2; rd_rs1_addr = 5'd5;
      tick();
      idle_inputs();
      n_tests++;
      if (rd_resp_valid !== 1'b1) begin
         n_fail++; $display("FAIL wr_rd_valid: got %b required 1", rd_resp_valid);
      end
      bad = -1;
      for (int i = 0; i < T; i++) if (rs1[i] !== 32'hA5A5_0000 + DW'(i) && bad < 0) bad = i;
      n_tests++;
      if (bad >= 0) begin
         n_fail++;
         $display("FAIL wr_rd_data lane %0d: got %h required %h", bad, rs1[bad], 32'hA5A5_0000 + DW'(bad));
      end
      tick();
      n_tests++;
      if (rd_resp_valid !== 1'b0 || rs1[3] !== 32'hA5A5_0003) begin
         n_fail++;
         $display("FAIL resp_hold: valid=%b rs1[3]=%h required 0 a5a50003", rd_resp_valid, rs1[3]);
      end
      rd_req_valid = 1'b1; rd_warp = 2'd1; rd_rs1_addr = 5'd5;
      tick();
      idle_inputs();
      bad = -1;
      for (int i = 0; i < T; i++) if (rs1[i] !== '0 && bad < 0) bad = i;
      n_tests++;
      if (bad >= 0) begin
         n_fail++; $display("FAIL warp_isolation lane %0d: got %h required 0", bad, rs1[bad]);
      end
   endtask

   task automatic test_bypass();
      int bad;
      logic [DW-1:0] want;
      write_all(0, 3, 32'd1);
      for (int i = 0; i < T; i++) wr_data[i] = 32'd1;
      tick();
      wr_thread_mask = 16'h00FF;
      for (int i = 0; i < T; i++) wr_data[i] = 32'd7;
      rd_req_valid = 1'b1; rd_warp = 2'd0; rd_rs1_addr = 5'd3; rd_rs2_addr = 5'd3;
      tick();
      idle_inputs();
      bad = -1;
      for (int i = 0; i < T; i++) begin
         want = (i < 8) ? 32'd7 : 32'd1;
         if ((rs1[i] !== want || rs2[i] !== want) && bad < 0) bad = i;
      end
      n_tests++;
      if (bad >= 0) begin
         n_fail++;
         $display("FAIL bypass lane %0d: rs1=%h rs2=%h required %h", bad, rs1[bad], rs2[bad],
                  (bad < 8) ? 32'd7 : 32'd1);
      end
   endtask

   task automatic test_special();
      int bad;
      write_all(3, 0, 32'h1234);
      tick();
      write_all(3, 31, 32'h1234);
      tick();
      idle_inputs();
      block_size = 32'd64; block_id = 32'h77;
      rd_req_valid = 1'b1; rd_warp = 2'd3; rd_rs1_addr = 5'd0; rd_rs2_addr = 5'd31;
      tick();
      bad = -1;
      for (int i = 0; i < T; i++) if ((rs1[i] !== '0 || rs2[i] !== 32'd64) && bad < 0) bad = i;
      n_tests++;
      if (bad >= 0) begin
         n_fail++;
         $display("FAIL zero_bsize lane %0d: rs1=%h rs2=%h required 0 40", bad, rs1[bad], rs2[bad]);
      end
      rd_rs1_addr = 5'd29; rd_rs2_addr = 5'd30;
      tick();
      idle_inputs();
      bad = -1;
      for (int i = 0; i < T; i++)
         if ((rs1[i] !== DW'(48 + i) || rs2[i] !== 32'h77) && bad < 0) bad = i;
      n_tests++;
      if (bad >= 0) begin
         n_fail++;
         $display("FAIL tid_bid lane %0d: rs1=%h rs2=%h required %h 77", bad, rs1[bad], rs2[bad], 48 + bad);
      end
   endtask

   task automatic test_clear();
      int bad;
      for (int r = 1; r <= 28; r++) begin
         write_all(1, r, $urandom | 32'h1);
         tick();
      end
      write_all(0, 6, 32'h1111_0000);
      tick();
      idle_inputs();
      clr_start = 1'b1; clr_warp = 2'd1;
      tick();
      idle_inputs();
      for (int k = 0; k < R - 1; k++) begin
         n_tests++;
         if (clr_busy !== 1'b1 || rd_req_ready !== 1'b0 || rd_resp_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL clear_busy cycle %0d: busy=%b ready=%b valid=%b required 1 0 0",
                     k, clr_busy, rd_req_ready, rd_resp_valid);
         end
         idle_inputs();
         rd_req_valid = 1'b1; rd_warp = 2'd1; rd_rs1_addr = 5'd4;
         if (k == 5) write_all(1, 4, 32'hDEAD_0000);
         if (k == 10) write_all(0, 6, 32'hCAFE_0000);
         if (k == 15) begin clr_start = 1'b1; clr_warp = 2'd2; end
         tick();
      end
      idle_inputs();
      n_tests++;
      if (clr_busy !== 1'b0 || rd_req_ready !== 1'b1) begin
         n_fail++; $display("FAIL clear_done: busy=%b ready=%b required 0 1", clr_busy, rd_req_ready);
      end
      bad = -1;
      for (int r = 1; r <= 28; r++) begin
         rd_req_valid = 1'b1; rd_warp = 2'd1; rd_rs1_addr = RW'(r); rd_rs2_addr = RW'(r);
         tick();
         for (int i = 0; i < T; i++) if ((rs1[i] !== '0 || rs2[i] !== '0) && bad < 0) bad = r;
      end
      n_tests++;
      if (bad >= 0) begin
         n_fail++; $display("FAIL clear_zero reg %0d: rs1[0]=%h required 0", bad, rs1[0]);
      end
      rd_warp = 2'd0; rd_rs1_addr = 5'd6; rd_rs2_addr = 5'd6;
      tick();
      rd_warp = 2'd2; rd_rs1_addr = 5'd5;
      bad = -1;
      for (int i = 0; i < T; i++) if (rs1[i] !== 32'hCAFE_0000 + DW'(i) && bad < 0) bad = i;
      n_tests++;
      if (bad >= 0) begin
         n_fail++; $display("FAIL clear_other_warp lane %0d: got %h required %h", bad, rs1[bad], 32'hCAFE_0000 + DW'(bad));
      end
      tick();
      idle_inputs();
      n_tests++;
      if (rs1[7] !== 32'hA5A5_0007) begin
         n_fail++; $display("FAIL clear_ignored_start: got %h required a5a50007", rs1[7]);
      end
   endtask

   task automatic random_inputs(bit allow_clr, bit allow_rd);
      bit near;
      near = ($urandom_range(0, 1) == 1);
      block_id   = $urandom;
      block_size = $urandom;
      wr_valid   = ($urandom_range(0, 2) != 0);
      wr_warp    = WW'($urandom_range(0, NW - 1));
      wr_rd_addr = near ? RW'($urandom_range(0, 7)) : RW'($urandom_range(0, R - 1));
      wr_thread_mask = T'($urandom);
      for (int i = 0; i < T; i++) wr_data[i] = $urandom;
      rd_req_valid = allow_rd && ($urandom_range(0, 2) != 0);
      rd_warp      = ($urandom_range(0, 1) == 1) ? wr_warp : WW'($urandom_range(0, NW - 1));
      rd_rs1_addr  = near ? wr_rd_addr : RW'($urandom_range(0, R - 1));
      rd_rs2_addr  = RW'($urandom_range(0, R - 1));
      clr_start    = allow_clr && ($urandom_range(0, 49) == 0);
      clr_warp     = WW'($urandom_range(0, NW - 1));
   endtask

   task automatic test_random();
      int bad;
      for (int c = 0; c < 400; c++) begin
         random_inputs(1'b1, 1'b1);
         tick();
         n_tests++;
         if (rd_resp_valid !== exp_valid) begin
            n_fail++; $display("FAIL rnd_valid cycle %0d: got %b required %b", c, rd_resp_valid, exp_valid);
         end
         n_tests++;
         if (clr_busy !== (clr_left > 0) || rd_req_ready !== !(clr_left > 0)) begin
            n_fail++;
            $display("FAIL rnd_busy cycle %0d: busy=%b ready=%b required busy %b", c, clr_busy, rd_req_ready, clr_left > 0);
         end
         bad = -1;
         for (int i = 0; i < T; i++) if ((rs1[i] !== exp_rs1[i] || rs2[i] !== exp_rs2[i]) && bad < 0) bad = i;
         n_tests++;
         if (bad >= 0) begin
            n_fail++;
            $display("FAIL rnd_data cycle %0d lane %0d: rs1=%h rs2=%h required %h %h",
                     c, bad, rs1[bad], rs2[bad], exp_rs1[bad], exp_rs2[bad]);
         end
      end
      idle_inputs();
      while (clr_left > 0) tick();
   endtask

   task automatic test_reset_mid_clear();
      int bad;
      for (int c = 0; c < 60; c++) begin
         random_inputs(1'b0, 1'b0);
         wr_valid = 1'b1;
         tick();
      end
      idle_inputs();
      clr_start = 1'b1; clr_warp = 2'd2;
      rd_req_valid = 1'b1; rd_warp = 2'd0; rd_rs1_addr = 5'd29;
      tick();
      idle_inputs();
      n_tests++;
      if (clr_busy !== 1'b1 || rd_resp_valid !== 1'b1) begin
         n_fail++; $display("FAIL pre_reset: busy=%b valid=%b required 1 1", clr_busy, rd_resp_valid);
      end
      #2;
      reset_n = 1'b0;
      #1;
      n_tests++;
      if (clr_busy !== 1'b0 || rd_resp_valid !== 1'b0 || rs1[5] !== '0) begin
         n_fail++;
         $display("FAIL async_reset: busy=%b valid=%b rs1[5]=%h required 0 0 0", clr_busy, rd_resp_valid, rs1[5]);
      end
      write_all(1, 7, 32'h5555_0000);
      rd_req_valid = 1'b1;
      @(posedge clk);
      @(posedge clk);
      #1;
      idle_inputs();
      reset_n = 1'b1;
      model_reset();
      n_tests++;
      if (rd_resp_valid !== 1'b0 || clr_busy !== 1'b0) begin
         n_fail++; $display("FAIL reset_held: valid=%b busy=%b required 0 0", rd_resp_valid, clr_busy);
      end
      block_id = 32'h0BAD_0001; block_size = 32'd128;
      bad = -1;
      for (int w = 0; w < NW; w++)
         for (int r = 0; r < R; r++) begin
            rd_req_valid = 1'b1; rd_warp = WW'(w); rd_rs1_addr = RW'(r); rd_rs2_addr = RW'(R - 1 - r);
            tick();
            for (int i = 0; i < T; i++)
               if ((rs1[i] !== exp_rs1[i] || rs2[i] !== exp_rs2[i]) && bad < 0) bad = w * R + r;
         end
      idle_inputs();
      n_tests++;
      if (bad >= 0) begin
         n_fail++;
         $display("FAIL post_reset_read warp %0d reg %0d: rs1[0]=%h required %h", bad / R, bad % R, rs1[0], exp_rs1[0]);
      end
   endtask

   initial begin
      #2_000_000;
      $display("FAIL timeout: simulation did not complete");
      $fatal(1);
   end

   initial begin
      test_reset();
      test_write_read();
      test_bypass();
      test_special();
      test_clear();
      test_random();
      test_reset_mid_clear();
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

// File: doc/warp_reg_file.md
WARP_REG_FILE -- requirements
Module: warp_reg_file

Interface
REQ-001 Parameter THREADS_PER_WARP, default 16, lanes per warp.
REQ-002 Parameter NUM_WARPS, default 4, resident warps with private register sets.
REQ-003 Parameter DATA_WIDTH, default `DATA_WIDTH, register width.
REQ-004 Parameter NUM_REGS, default 32, registers per lane (power of two, >= 8); RW = log2(NUM_REGS), WW = max(1, log2(NUM_WARPS)).
REQ-005 Parameter HAS_SPECIAL_REGS, default 1, enables read-only registers NUM_REGS-3 (thread id), NUM_REGS-2 (block id), NUM_REGS-1 (block size).
REQ-006 clk  in  1  single clock; all state updates on rising edge.
REQ-007 reset_n  in  1  asynchronous, active-low reset.
REQ-008 block_id, block_size  in  DATA_WIDTH each  special-register sources.
REQ-009 rd_req_valid in 1, rd_req_ready out 1  read request handshake.
REQ-010 rd_warp in WW; rd_rs1_addr, rd_rs2_addr in RW  read target.
REQ-011 rd_resp_valid out 1; rs1, rs2 out data_t [THREADS_PER_WARP]  read response.
REQ-012 wr_valid in 1; wr_warp in WW; wr_rd_addr in RW; wr_thread_mask in THREADS_PER_WARP; wr_data in data_t [THREADS_PER_WARP]  write port (always accepted).
REQ-013 clr_start in 1; clr_warp in WW; clr_busy out 1  warp-clear command and status.

Function
REQ-014 Read accepted when rd_req_valid && rd_req_ready; rs1/rs2 registered at that edge, rd_resp_valid high exactly the following cycle (latency 1).
REQ-015 rs1/rs2 hold last response until next accepted read; rd_resp_valid low in cycles without acceptance.
REQ-016 Address 0 reads 0; with HAS_SPECIAL_REGS, thread-id reads return rd_warp*THREADS_PER_WARP + lane, block-id/block-size read live inputs at acceptance edge.
REQ-017 Write on edge with wr_valid updates wr_data[i] into [wr_warp][lane i][wr_rd_addr] only for lanes with wr_thread_mask[i]=1.
REQ-018 Writes to address 0 and (HAS_SPECIAL_REGS) to the three special addresses are dropped silently.
REQ-019 Same-edge write and accepted read of identical warp/address: response returns new data for masked lanes, old data for unmasked lanes (write-first bypass).
REQ-020 FSM states IDLE, CLEAR; reset state IDLE.
REQ-021 IDLE -> CLEAR on clr_start; latches clr_warp, counter loaded with 1.
REQ-022 In CLEAR each cycle zeroes register counter in all lanes of latched warp, counter increments; after writing NUM_REGS-1 -> IDLE (NUM_REGS-1 CLEAR cycles).
REQ-023 clr_busy = (state == CLEAR); rd_req_ready = !clr_busy.
REQ-024 clr_start while CLEAR is ignored.
REQ-025 During CLEAR, writes to latched warp are dropped; writes to other warps proceed normally.
REQ-026 Special registers are never stored; CLEAR iterates over them without effect.

Reset
REQ-027 reset_n low immediately clears all registers of all warps/lanes, rs1/rs2 to 0, rd_resp_valid 0, clr_busy 0, FSM IDLE, counter 0.
REQ-028 Reset asserted mid-CLEAR aborts clearing; after release, FSM IDLE and all registers 0.
REQ-029 No read or write accepted while reset_n low.

Verification
REQ-030 Write warp 2 reg 5 all-lanes 0xA5A5_0000+lane, read warp 2 rs1=5 next cycle -> rd_resp_valid one cycle later, rs1[i]=0xA5A5_0000+i; warp 1 reg 5 reads 0.
REQ-031 Write mask 0x00FF value 7 to warp 0 reg 3 (prior 1) with same-edge read of reg 3 -> rs1 lanes 0-7 = 7, lanes 8-15 = 1.
REQ-032 Write 0x1234 to reg 0 and reg 31; read rs1=0, rs2=31 on warp 3 with block_size=64 -> rs1=0, rs2=64 all lanes; read reg 29 warp 3 -> rs1[i]=48+i.
REQ-033 clr_start warp 1 with warp 1 populated -> clr_busy high 31 cycles, rd_req_ready low; concurrent write to warp 1 dropped, warp 0 write lands; afterwards warp 1 regs 1-28 read 0.
REQ-034 Populate registers, assert reset_n low mid-CLEAR for 2 cycles -> clr_busy 0 and rd_resp_valid 0 immediately; all later reads return 0 except special registers.
